// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's mem_* load/store bus.
// Block-RAM word store with byte-lane steering. Loads return after READ_LATENCY
// cycles, right-shifted by the byte offset. Stores complete on the accept edge.
// Optional build macro DMEM_MISALIGN_CHK_EN adds a mem_err output. With it,
// misaligned halfword and word stores are accepted but dropped, and mem_err
// pulses for one cycle.
module dmem_responder #(
  parameter int          ADDR_WIDTH   = 14,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic        mem_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(READ_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  logic [31:0] mem [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [31:0]       ram_dout_q, ram_dout_d;
  logic [1:0]        off_q, off_d;
  logic              inrange_q, inrange_d;
  logic              err_q, err_d;

  logic                  accept;
  logic                  load_accept;
  logic                  store_accept;
  logic                  in_range;
  logic                  misaligned;
  logic [1:0]            byte_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [3:0]            wr_lanes;
  logic [31:0]           wr_data;
  logic [3:0]            ram_we;
  logic [31:0]           shaped;

  assign byte_off = mem_addr[1:0];
  assign ram_idx  = mem_addr[ADDR_WIDTH+1:2];
  assign in_range = (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  // Decode the bus request into accept strobes and steered store lanes/data.
  // Lanes shifted past bit 3 fall off the 4-bit result and are discarded.
  always_comb begin
    accept       = mem_oe && ready_q;
    load_accept  = accept && (mem_we == 4'b0000);
    store_accept = accept && (mem_we != 4'b0000);
    wr_lanes     = mem_we << byte_off;
    wr_data      = mem_wdata << {byte_off, 3'b000};
`ifdef DMEM_MISALIGN_CHK_EN
    misaligned   = ((mem_we == 4'b0011) && byte_off[0]) ||
                   ((mem_we == 4'b1111) && (byte_off != 2'b00));
`else
    misaligned   = 1'b0;
`endif
    ram_we       = 4'b0000;
    if (store_accept && in_range && !misaligned) begin
      ram_we = wr_lanes;
    end
  end

  // RAM write port: byte-enabled write at the store accept edge.
  // RAM contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) begin
        mem[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Load capture: raw word, byte offset and range flag are taken at load accept.
  // Stores leave them alone, so the load result holds across stores.
  always_comb begin
    ram_dout_d = ram_dout_q;
    off_d      = off_q;
    inrange_d  = inrange_q;
    if (load_accept) begin
      ram_dout_d = mem[ram_idx];
      off_d      = byte_off;
      inrange_d  = in_range;
    end
  end

  // Handshake FSM: IDLE accepts requests; WAIT counts down an outstanding load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    valid_d = 1'b0;
    err_d   = store_accept && misaligned;
    case (state_q)
      S_IDLE: begin
        if (load_accept) begin
          if (READ_LATENCY == 1) begin
            valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
            ready_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          valid_d = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers. Reset abandons any outstanding load and holds ready low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      ram_dout_q <= '0;
      off_q      <= 2'b00;
      inrange_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      ram_dout_q <= ram_dout_d;
      off_q      <= off_d;
      inrange_q  <= inrange_d;
      err_q      <= err_d;
    end
  end

  assign shaped = inrange_q ? (ram_dout_q >> {off_q, 3'b000}) : 32'h0000_0000;

  if (READ_LATENCY == 1) begin : g_lat1
    // With single-cycle latency the captured word is already the load result.
    assign mem_rdata = shaped;
  end else begin : g_latn
    logic [31:0] rdata_q, rdata_d;

    // Publish the load result only in the valid cycle so earlier loads hold.
    always_comb begin
      rdata_d = valid_d ? shaped : rdata_q;
    end

    // Result register for multi-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign mem_rdata = rdata_q;
  end

  assign mem_valid = valid_q;
  assign mem_ready = ready_q;
`ifdef DMEM_MISALIGN_CHK_EN
  assign mem_err   = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// Two instances are used: one with READ_LATENCY=1 and one with READ_LATENCY=3.
// A selector routes mem_oe and observes outputs for one instance at a time.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        oe;
  int          dut_sel;

  logic [31:0] r1_rdata, r3_rdata;
  logic        v1, v3, rd1, rd3;
  logic        e1, e3;

  logic [31:0] cur_rdata;
  logic        cur_valid, cur_ready, cur_err;

  int checks;
  int failures;
  int lat;
  logic [31:0] d;

  always #5 clk = ~clk;

`ifndef DMEM_MISALIGN_CHK_EN
  assign e1 = 1'b0;
  assign e3 = 1'b0;
`endif

  dmem_responder #(.ADDR_WIDTH(14), .READ_LATENCY(1), .BASE_ADDR(BASE)) u_lat1 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_oe(oe && (dut_sel == 1)),
    .mem_wdata(wdata), .mem_we(we), .mem_rdata(r1_rdata), .mem_valid(v1),
    .mem_ready(rd1)
`ifdef DMEM_MISALIGN_CHK_EN
    , .mem_err(e1)
`endif
  );

  dmem_responder #(.ADDR_WIDTH(14), .READ_LATENCY(3), .BASE_ADDR(BASE)) u_lat3 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_oe(oe && (dut_sel == 3)),
    .mem_wdata(wdata), .mem_we(we), .mem_rdata(r3_rdata), .mem_valid(v3),
    .mem_ready(rd3)
`ifdef DMEM_MISALIGN_CHK_EN
    , .mem_err(e3)
`endif
  );

  assign cur_rdata = (dut_sel == 3) ? r3_rdata : r1_rdata;
  assign cur_valid = (dut_sel == 3) ? v3 : v1;
  assign cur_ready = (dut_sel == 3) ? rd3 : rd1;
  assign cur_err   = (dut_sel == 3) ? e3 : e1;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] dat);
    addr = a; we = w; wdata = dat; oe = 1'b1;
    step();
    oe = 1'b0; we = 4'b0000;
  endtask

  task automatic load(input logic [31:0] a, output int l, output logic [31:0] res);
    addr = a; we = 4'b0000; oe = 1'b1;
    step();
    oe = 1'b0;
    l = 1;
    while (cur_valid !== 1'b1 && l < 12) begin
      step();
      l++;
    end
    res = cur_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (v1 !== 1'b0 || rd1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_l1_hs got valid=%b ready=%b exp 0/0", v1, rd1); end
    checks++; if (r1_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_l1_rdata got=%h exp=0", r1_rdata); end
    checks++; if (v3 !== 1'b0 || rd3 !== 1'b0 || r3_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_l3 got valid=%b ready=%b rdata=%h exp 0", v3, rd3, r3_rdata); end
    checks++; if (e1 !== 1'b0 || e3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b%b exp=00", e1, e3); end
    rst = 1'b0;
    #1;
    checks++; if (rd1 !== 1'b0) begin failures++; $display("[TB] FAIL ready_before_edge got=%b exp=0", rd1); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (rd1 !== 1'b1 || rd3 !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_edge got=%b%b exp=11", rd1, rd3); end
  endtask

  task automatic test_word_store_load();
    dut_sel = 1;
    store(BASE + 32'h10, 4'b1111, 32'hDEADBEEF);
    checks++; if (cur_ready !== 1'b1 || cur_valid !== 1'b0) begin failures++; $display("[TB] FAIL store_hs got ready=%b valid=%b exp 1/0", cur_ready, cur_valid); end
    load(BASE + 32'h10, lat, d);
    checks++; if (lat != 1) begin failures++; $display("[TB] FAIL sw_load_lat got=%0d exp=1", lat); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL sw_load_data got=%h exp=deadbeef", d); end
    step();
    checks++; if (cur_valid !== 1'b0) begin failures++; $display("[TB] FAIL valid_pulse got=%b exp=0", cur_valid); end
  endtask

  task automatic test_byte_half_lanes();
    dut_sel = 1;
    store(BASE + 32'h13, 4'b0001, 32'h000000AA);
    load(BASE + 32'h10, lat, d);
    checks++; if (d !== 32'hAAADBEEF) begin failures++; $display("[TB] FAIL sb_word got=%h exp=aaadbeef", d); end
    load(BASE + 32'h13, lat, d);
    checks++; if (d !== 32'h000000AA) begin failures++; $display("[TB] FAIL sb_byte_load got=%h exp=000000aa", d); end
    store(BASE + 32'h14, 4'b1111, 32'h11223344);
    store(BASE + 32'h16, 4'b0011, 32'hBEEF5678);
    load(BASE + 32'h14, lat, d);
    checks++; if (d !== 32'h56783344) begin failures++; $display("[TB] FAIL sh_word got=%h exp=56783344", d); end
    load(BASE + 32'h16, lat, d);
    checks++; if (d !== 32'h00005678) begin failures++; $display("[TB] FAIL sh_half_load got=%h exp=00005678", d); end
    store(BASE + 32'h18, 4'b0001, 32'h00000077);
    checks++; if (cur_rdata !== 32'h00005678 || cur_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdata_hold_on_store got=%h valid=%b exp=00005678/0", cur_rdata, cur_valid); end
  endtask

  task automatic test_back_to_back();
    dut_sel = 1;
    addr = BASE + 32'h10; we = 4'b0000; oe = 1'b1;
    step();
    checks++; if (cur_valid !== 1'b1 || cur_ready !== 1'b1 || cur_rdata !== 32'hAAADBEEF) begin failures++; $display("[TB] FAIL b2b_first got valid=%b ready=%b rdata=%h exp 1/1/aaadbeef", cur_valid, cur_ready, cur_rdata); end
    addr = BASE + 32'h14;
    step();
    oe = 1'b0;
    checks++; if (cur_valid !== 1'b1 || cur_rdata !== 32'h56783344) begin failures++; $display("[TB] FAIL b2b_second got valid=%b rdata=%h exp 1/56783344", cur_valid, cur_rdata); end
    step();
    checks++; if (cur_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%b exp=0", cur_valid); end
  endtask

  task automatic test_out_of_range();
    dut_sel = 1;
    store(BASE, 4'b1111, 32'h13579BDF);
    load(32'h0000_0000, lat, d);
    checks++; if (lat != 1 || d !== 32'h0) begin failures++; $display("[TB] FAIL oor_load got lat=%0d rdata=%h exp 1/0", lat, d); end
    load(32'h0003_0010, lat, d);
    checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL oor_alias_load got=%h exp=0", d); end
    store(32'h0000_0000, 4'b1111, 32'hFFFFFFFF);
    load(BASE, lat, d);
    checks++; if (d !== 32'h13579BDF) begin failures++; $display("[TB] FAIL oor_store_dropped got=%h exp=13579bdf", d); end
  endtask

  task automatic test_latency3();
    dut_sel = 3;
    store(BASE + 32'h40, 4'b1111, 32'h0BADF00D);
    store(BASE + 32'h44, 4'b1111, 32'h600DCAFE);
    addr = BASE + 32'h40; we = 4'b0000; oe = 1'b1;
    step();
    addr = BASE + 32'h48; we = 4'b1111; wdata = 32'h99999999;
    checks++; if (cur_ready !== 1'b0 || cur_valid !== 1'b0) begin failures++; $display("[TB] FAIL l3_t1 got ready=%b valid=%b exp 0/0", cur_ready, cur_valid); end
    step();
    oe = 1'b0; we = 4'b0000;
    checks++; if (cur_ready !== 1'b0 || cur_valid !== 1'b0) begin failures++; $display("[TB] FAIL l3_t2 got ready=%b valid=%b exp 0/0", cur_ready, cur_valid); end
    step();
    checks++; if (cur_valid !== 1'b1 || cur_ready !== 1'b1 || cur_rdata !== 32'h0BADF00D) begin failures++; $display("[TB] FAIL l3_t3 got valid=%b ready=%b rdata=%h exp 1/1/0badf00d", cur_valid, cur_ready, cur_rdata); end
    addr = BASE + 32'h44; oe = 1'b1;
    step();
    oe = 1'b0;
    checks++; if (cur_ready !== 1'b0 || cur_valid !== 1'b0 || cur_rdata !== 32'h0BADF00D) begin failures++; $display("[TB] FAIL l3_t4 got ready=%b valid=%b rdata=%h exp 0/0/0badf00d", cur_ready, cur_valid, cur_rdata); end
    step();
    step();
    checks++; if (cur_valid !== 1'b1 || cur_rdata !== 32'h600DCAFE) begin failures++; $display("[TB] FAIL l3_t6 got valid=%b rdata=%h exp 1/600dcafe", cur_valid, cur_rdata); end
    step();
    checks++; if (cur_valid !== 1'b0 || cur_ready !== 1'b1) begin failures++; $display("[TB] FAIL l3_t7 got valid=%b ready=%b exp 0/1", cur_valid, cur_ready); end
    store(BASE + 32'h48, 4'b1111, 32'h00000001);
    addr = BASE + 32'h48;
    load(BASE + 32'h48, lat, d);
    checks++; if (lat != 3 || d !== 32'h00000001) begin failures++; $display("[TB] FAIL l3_wait_store_ignored got lat=%0d rdata=%h exp 3/00000001", lat, d); end
  endtask

  task automatic test_reset_mid_load();
    logic saw_valid;
    dut_sel = 3;
    addr = BASE + 32'h40; we = 4'b0000; oe = 1'b1;
    step();
    oe = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (cur_valid !== 1'b0 || cur_ready !== 1'b0 || cur_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid got valid=%b ready=%b rdata=%h exp 0/0/0", cur_valid, cur_ready, cur_rdata); end
    step();
    step();
    checks++; if (cur_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_hold_ready got=%b exp=0", cur_ready); end
    rst = 1'b0;
    #1;
    checks++; if (cur_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_release_ready got=%b exp=0", cur_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (cur_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready_edge got=%b exp=1", cur_ready); end
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cur_valid !== 1'b0) saw_valid = 1'b1;
      step();
    end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_abandon got valid_seen=%b exp=0", saw_valid); end
  endtask

  task automatic test_misaligned();
    dut_sel = 1;
    store(BASE + 32'h20, 4'b1111, 32'hA5A5A5A5);
    store(BASE + 32'h21, 4'b1111, 32'h12345678);
`ifdef DMEM_MISALIGN_CHK_EN
    checks++; if (cur_err !== 1'b1 || cur_ready !== 1'b1) begin failures++; $display("[TB] FAIL mis_sw_err got err=%b ready=%b exp 1/1", cur_err, cur_ready); end
    step();
    checks++; if (cur_err !== 1'b0) begin failures++; $display("[TB] FAIL mis_err_pulse got=%b exp=0", cur_err); end
    load(BASE + 32'h20, lat, d);
    checks++; if (d !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL mis_sw_dropped got=%h exp=a5a5a5a5", d); end
    store(BASE + 32'h17, 4'b0011, 32'h0000CAFE);
    checks++; if (cur_err !== 1'b1) begin failures++; $display("[TB] FAIL mis_sh_err got=%b exp=1", cur_err); end
    load(BASE + 32'h14, lat, d);
    checks++; if (d !== 32'h56783344 || cur_err !== 1'b0) begin failures++; $display("[TB] FAIL mis_sh_dropped got=%h err=%b exp=56783344/0", d, cur_err); end
    load(BASE + 32'h21, lat, d);
    checks++; if (cur_err !== 1'b0) begin failures++; $display("[TB] FAIL mis_load_no_err got=%b exp=0", cur_err); end
    store(BASE + 32'h16, 4'b0011, 32'h00001111);
    checks++; if (cur_err !== 1'b0) begin failures++; $display("[TB] FAIL aligned_sh_no_err got=%b exp=0", cur_err); end
`else
    checks++; if (cur_err !== 1'b0 || cur_ready !== 1'b1) begin failures++; $display("[TB] FAIL mis_sw_hs got err=%b ready=%b exp 0/1", cur_err, cur_ready); end
    load(BASE + 32'h20, lat, d);
    checks++; if (d !== 32'h345678A5) begin failures++; $display("[TB] FAIL mis_sw_trunc got=%h exp=345678a5", d); end
    store(BASE + 32'h17, 4'b0011, 32'h0000CAFE);
    load(BASE + 32'h14, lat, d);
    checks++; if (d !== 32'hFE783344) begin failures++; $display("[TB] FAIL mis_sh_trunc got=%h exp=fe783344", d); end
`endif
  endtask

  initial begin
    rst = 1'b1; oe = 1'b0; we = 4'b0000; addr = 32'h0; wdata = 32'h0;
    dut_sel = 1; checks = 0; failures = 0;
    @(negedge clk);
    test_reset();
    test_word_store_load();
    test_byte_half_lanes();
    test_back_to_back();
    test_out_of_range();
    test_latency3();
    test_reset_mid_load();
    test_misaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
